// File: rtl/one_unit_div3.sv
// Sequential divide-by-3 of a 4x4 signed 26-bit matrix on one shared restoring divider.
// Optional build macro ONE_UNIT_DIV3_ROUND_EN selects round-to-nearest instead of truncation.
module one_unit_div3 (
  input  logic               clk_div,
  input  logic               rst_div,
  input  logic               start_div,
  input  logic signed [25:0] iw11, iw12, iw13, iw14,
  input  logic signed [25:0] iw21, iw22, iw23, iw24,
  input  logic signed [25:0] iw31, iw32, iw33, iw34,
  input  logic signed [25:0] iw41, iw42, iw43, iw44,
  output logic               busy_div,
  output logic               done_div,
  output logic signed [25:0] ow11, ow12, ow13, ow14,
  output logic signed [25:0] ow21, ow22, ow23, ow24,
  output logic signed [25:0] ow31, ow32, ow33, ow34,
  output logic signed [25:0] ow41, ow42, ow43, ow44
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] iw_s   [16];
  logic [25:0] snap_q [16];
  logic [25:0] snap_d [16];
  logic [25:0] ow_q   [16];
  logic [25:0] ow_d   [16];
  logic [3:0]  e_q, e_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [25:0] mag_q, mag_d;
  logic [1:0]  rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [25:0] cur_s;
  logic [2:0]  rem_sh_s;
  logic [2:0]  rem_sub_s;
  logic [25:0] q_mag_s;

  assign iw_s[0]  = iw11;  assign iw_s[1]  = iw12;  assign iw_s[2]  = iw13;  assign iw_s[3]  = iw14;
  assign iw_s[4]  = iw21;  assign iw_s[5]  = iw22;  assign iw_s[6]  = iw23;  assign iw_s[7]  = iw24;
  assign iw_s[8]  = iw31;  assign iw_s[9]  = iw32;  assign iw_s[10] = iw33;  assign iw_s[11] = iw34;
  assign iw_s[12] = iw41;  assign iw_s[13] = iw42;  assign iw_s[14] = iw43;  assign iw_s[15] = iw44;

  assign cur_s     = snap_q[e_q];
  assign rem_sh_s  = {rem_q, mag_q[25]};
  assign rem_sub_s = rem_sh_s - 3'd3;
`ifdef ONE_UNIT_DIV3_ROUND_EN
  // A remainder of 2 means the fractional part is 2/3, so round the magnitude up.
  assign q_mag_s   = mag_q + {25'd0, (rem_q == 2'd2)};
`else
  assign q_mag_s   = mag_q;
`endif

  // Next-state, divider datapath and output register updates.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ow_d    = ow_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start_div) begin
          snap_d  = iw_s;
          e_d     = 4'd0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        neg_d   = cur_s[25];
        mag_d   = cur_s[25] ? (~cur_s + 26'd1) : cur_s;
        rem_d   = 2'd0;
        cnt_d   = 5'd25;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (rem_sh_s >= 3'd3) begin
          rem_d = rem_sub_s[1:0];
          mag_d = {mag_q[24:0], 1'b1};
        end else begin
          rem_d = rem_sh_s[1:0];
          mag_d = {mag_q[24:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_STORE;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = S_DIV;
        end
      end
      S_STORE: begin
        ow_d[e_q] = neg_q ? (~q_mag_s + 26'd1) : q_mag_s;
        if (e_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          e_d     = e_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_DIV) || (state_d == S_STORE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_div) begin
    if (rst_div) begin
      state_q <= S_IDLE;
      e_q     <= 4'd0;
      cnt_q   <= 5'd0;
      mag_q   <= 26'd0;
      rem_q   <= 2'd0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        snap_q[i] <= 26'd0;
        ow_q[i]   <= 26'd0;
      end
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
      ow_q    <= ow_d;
    end
  end

  assign busy_div = busy_q;
  assign done_div = done_q;
  assign ow11 = ow_q[0];   assign ow12 = ow_q[1];   assign ow13 = ow_q[2];   assign ow14 = ow_q[3];
  assign ow21 = ow_q[4];   assign ow22 = ow_q[5];   assign ow23 = ow_q[6];   assign ow24 = ow_q[7];
  assign ow31 = ow_q[8];   assign ow32 = ow_q[9];   assign ow33 = ow_q[10];  assign ow34 = ow_q[11];
  assign ow41 = ow_q[12];  assign ow42 = ow_q[13];  assign ow43 = ow_q[14];  assign ow44 = ow_q[15];

endmodule
